// File: rtl/run_monitor.sv
// Run-control and physical-memory protocol monitor for the mp3 core: halt, timeout and per-channel handshake checks.
// Optional macro RUN_MONITOR_STALL_EN: every PC load re-arms the timeout, turning it into a stall detector.
module run_monitor #(
    parameter int unsigned NUM_CH     = 2,
    parameter logic [31:0] HALT_ADDR  = 32'h0000011c,
    parameter int unsigned HALT_COUNT = 2,
    parameter int unsigned TIMEOUT    = 100000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_pc,
    input  logic [31:0]         pc_out,
    input  logic [NUM_CH-1:0]   pmem_read,
    input  logic [NUM_CH-1:0]   pmem_write,
    input  logic [NUM_CH-1:0]   pmem_resp,
    output logic [1:0]          status,
    output logic                done,
    output logic [3*NUM_CH-1:0] mem_err,
    output logic [31:0]         cycle_count,
    output logic [31:0]         retire_count
);

    localparam logic [31:0] TMO_RELOAD  = 32'(TIMEOUT - 1);
    localparam logic [7:0]  HALT_TARGET = 8'(HALT_COUNT);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALTED  = 2'd1,
        ST_TIMEOUT = 2'd2,
        ST_FAULT   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_RD   = 2'd1,
        CH_WR   = 2'd2
    } ch_state_e;

    state_e              state_q;
    logic                done_q;
    logic [3*NUM_CH-1:0] mem_err_q;
    logic [31:0]         cycle_q;
    logic [31:0]         retire_q;
    logic [7:0]          match_q;
    logic [31:0]         tmo_q;

    logic [3*NUM_CH-1:0] err_set;
    logic                halt_hit;
    logic                halt_last;
    logic                tmo_reload;
    logic                tmo_expire;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        ch_state_e  ch_q;
        ch_state_e  ch_d;
        logic [2:0] err_d;
        logic       rd;
        logic       wr;
        logic       rsp;

        assign rd  = pmem_read[gi];
        assign wr  = pmem_write[gi];
        assign rsp = pmem_resp[gi];

        always_comb begin
            ch_d     = ch_q;
            err_d    = 3'b000;
            err_d[0] = rd && wr;
            case (ch_q)
                CH_IDLE: begin
                    // A response in the starting cycle completes the transfer on the spot.
                    if (rd && !wr && !rsp) begin
                        ch_d = CH_RD;
                    end else if (wr && !rd && !rsp) begin
                        ch_d = CH_WR;
                    end else if (!rd && !wr && rsp) begin
                        err_d[2] = 1'b1;
                    end
                end
                CH_RD: begin
                    if (!rd || wr) begin
                        err_d[1] = 1'b1;
                        ch_d     = CH_IDLE;
                    end else if (rsp) begin
                        ch_d = CH_IDLE;
                    end
                end
                CH_WR: begin
                    if (!wr || rd) begin
                        err_d[1] = 1'b1;
                        ch_d     = CH_IDLE;
                    end else if (rsp) begin
                        ch_d = CH_IDLE;
                    end
                end
                default: ch_d = CH_IDLE;
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ch_q <= CH_IDLE;
            end else begin
                ch_q <= ch_d;
            end
        end

        assign err_set[3*gi +: 3] = err_d;
    end

    assign halt_hit  = load_pc && (pc_out == HALT_ADDR);
    assign halt_last = halt_hit && (match_q == HALT_TARGET - 8'd1);

`ifdef RUN_MONITOR_STALL_EN
    assign tmo_reload = load_pc;
`else
    assign tmo_reload = 1'b0;
`endif

    // A PC load in the expiring cycle re-arms the budget rather than firing.
    assign tmo_expire = (tmo_q == 32'd0) && !tmo_reload;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            done_q    <= 1'b0;
            mem_err_q <= '0;
            cycle_q   <= 32'd0;
            retire_q  <= 32'd0;
            match_q   <= 8'd0;
            tmo_q     <= TMO_RELOAD;
        end else begin
            mem_err_q <= mem_err_q | err_set;
            if (state_q == ST_RUN) begin
                if (cycle_q != 32'hffff_ffff) begin
                    cycle_q <= cycle_q + 32'd1;
                end
                if (load_pc && (retire_q != 32'hffff_ffff)) begin
                    retire_q <= retire_q + 32'd1;
                end
                if (halt_hit) begin
                    match_q <= match_q + 8'd1;
                end
                if (tmo_reload) begin
                    tmo_q <= TMO_RELOAD;
                end else if (tmo_q != 32'd0) begin
                    tmo_q <= tmo_q - 32'd1;
                end
                // Protocol faults outrank a halt, which outranks a timeout.
                if (|err_set) begin
                    state_q <= ST_FAULT;
                    done_q  <= 1'b1;
                end else if (halt_last) begin
                    state_q <= ST_HALTED;
                    done_q  <= 1'b1;
                end else if (tmo_expire) begin
                    state_q <= ST_TIMEOUT;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    assign status       = state_q;
    assign done         = done_q;
    assign mem_err      = mem_err_q;
    assign cycle_count  = cycle_q;
    assign retire_count = retire_q;

endmodule

// File: tb/tb_run_monitor.sv
// Directed self-checking bench for run_monitor: halt, timeout, protocol errors, priority and async reset.
module tb_run_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_pc;
    logic [31:0] pc_out;
    logic [1:0]  pmem_read;
    logic [1:0]  pmem_write;
    logic [1:0]  pmem_resp;
    logic [1:0]  status;
    logic        done;
    logic [5:0]  mem_err;
    logic [31:0] cycle_count;
    logic [31:0] retire_count;

    int n_cmp  = 0;
    int n_fail = 0;

    run_monitor #(
        .NUM_CH    (2),
        .HALT_ADDR (32'h0000011c),
        .HALT_COUNT(2),
        .TIMEOUT   (50)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_pc     (load_pc),
        .pc_out      (pc_out),
        .pmem_read   (pmem_read),
        .pmem_write  (pmem_write),
        .pmem_resp   (pmem_resp),
        .status      (status),
        .done        (done),
        .mem_err     (mem_err),
        .cycle_count (cycle_count),
        .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        load_pc    = 1'b0;
        pc_out     = 32'h0000_0000;
        pmem_read  = 2'b00;
        pmem_write = 2'b00;
        pmem_resp  = 2'b00;
    endtask

    // Leaves rst released 1 time unit after an edge; the next edge is edge 1.
    task automatic do_reset();
        clear_inputs();
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        #3;
        check("reset_status", status, 2'd0);
        check("reset_done", done, 1'b0);
        check("reset_mem_err", mem_err, 6'd0);
        check("reset_cycle", cycle_count, 32'd0);
        check("reset_retire", retire_count, 32'd0);
        $display("step reset: status=%0d done=%0b", status, done);

        // Halt: loads of HALT_ADDR at edges 10 and 20.
        do_reset();
        pc_out = 32'h0000011c;
        for (int e = 1; e <= 20; e++) begin
            load_pc = (e == 10) || (e == 20);
            tick();
            if (e == 19) check("halt_pre_status", status, 2'd0);
        end
        load_pc = 1'b0;
        check("halt_status", status, 2'd1);
        check("halt_done", done, 1'b1);
        check("halt_retire", retire_count, 32'd2);
        check("halt_cycle", cycle_count, 32'd20);
        for (int e = 0; e < 5; e++) begin
            load_pc = 1'b1;
            tick();
        end
        load_pc = 1'b0;
        check("halt_cycle_frozen", cycle_count, 32'd20);
        check("halt_retire_frozen", retire_count, 32'd2);
        check("halt_sticky", status, 2'd1);
        $display("step halt: status=%0d cycle=%0d retire=%0d", status, cycle_count, retire_count);

        // Timeout with no PC loads: fires on edge 50.
        do_reset();
        for (int e = 1; e <= 50; e++) begin
            tick();
            if (e == 49) check("tmo_pre_status", status, 2'd0);
        end
        check("tmo_status", status, 2'd2);
        check("tmo_done", done, 1'b1);
        check("tmo_cycle", cycle_count, 32'd50);
        $display("step timeout: status=%0d cycle=%0d", status, cycle_count);

        // Non-halt PC loads every 40 cycles.
        do_reset();
        pc_out = 32'h0000_0040;
`ifdef RUN_MONITOR_STALL_EN
        for (int e = 1; e <= 200; e++) begin
            load_pc = (e % 40) == 0;
            tick();
        end
        load_pc = 1'b0;
        check("stall_run_status", status, 2'd0);
        check("stall_run_cycle", cycle_count, 32'd200);
        check("stall_run_retire", retire_count, 32'd5);
        for (int e = 1; e <= 50; e++) begin
            tick();
            if (e == 49) check("stall_pre_status", status, 2'd0);
        end
        check("stall_tmo_status", status, 2'd2);
        check("stall_tmo_cycle", cycle_count, 32'd250);
`else
        for (int e = 1; e <= 60; e++) begin
            load_pc = (e % 40) == 0;
            tick();
            if (e == 49) check("budget_pre_status", status, 2'd0);
        end
        load_pc = 1'b0;
        check("budget_status", status, 2'd2);
        check("budget_cycle", cycle_count, 32'd50);
        check("budget_retire", retire_count, 32'd1);
`endif
        $display("step pc_loads_every_40: status=%0d cycle=%0d", status, cycle_count);

        // Halt and timeout on the same edge: halt wins.
        do_reset();
        pc_out = 32'h0000011c;
        for (int e = 1; e <= 50; e++) begin
            load_pc = (e == 1) || (e == 50);
            tick();
        end
        load_pc = 1'b0;
        check("halt_vs_tmo_status", status, 2'd1);
        check("halt_vs_tmo_cycle", cycle_count, 32'd50);
        $display("step halt_vs_timeout: status=%0d", status);

        // Channel 1 read and write together for one cycle.
        do_reset();
        tick();
        pmem_read  = 2'b10;
        pmem_write = 2'b10;
        tick();
        pmem_read  = 2'b00;
        pmem_write = 2'b00;
        check("ch1_rw_mem_err", mem_err, 6'b001000);
        check("ch1_rw_status", status, 2'd3);
        check("ch1_rw_done", done, 1'b1);
        $display("step ch1_rw: status=%0d mem_err=%b", status, mem_err);

        // Channel 0: 5-cycle read, same-cycle write, single-cycle read.
        do_reset();
        pmem_read = 2'b01;
        for (int e = 1; e <= 5; e++) begin
            pmem_resp = (e == 5) ? 2'b01 : 2'b00;
            tick();
            if (e == 3) check("ch0_rd_hold_err", mem_err, 6'd0);
        end
        pmem_read  = 2'b00;
        pmem_write = 2'b01;
        pmem_resp  = 2'b01;
        tick();
        pmem_write = 2'b00;
        pmem_read  = 2'b01;
        tick();
        clear_inputs();
        tick();
        check("ch0_b2b_mem_err", mem_err, 6'd0);
        check("ch0_b2b_status", status, 2'd0);
        check("ch0_b2b_cycle", cycle_count, 32'd8);
        $display("step ch0_back_to_back: status=%0d mem_err=%b", status, mem_err);

        // Channel 0: read dropped at edge 3, stray resp later.
        do_reset();
        pmem_read = 2'b01;
        tick();
        tick();
        pmem_read = 2'b00;
        tick();
        check("ch0_drop_mem_err", mem_err, 6'b000010);
        check("ch0_drop_status", status, 2'd3);
        tick();
        pmem_resp = 2'b01;
        tick();
        pmem_resp = 2'b00;
        check("ch0_stray_mem_err", mem_err, 6'b000110);
        check("ch0_stray_status", status, 2'd3);
        check("ch0_drop_cycle_frozen", cycle_count, 32'd3);
        $display("step ch0_drop_stray: status=%0d mem_err=%b", status, mem_err);

        // Start a read, then reset asynchronously mid-transfer.
        pmem_read = 2'b01;
        tick();
        tick();
        #3;
        rst = 1'b1;
        #1;
        check("async_status", status, 2'd0);
        check("async_done", done, 1'b0);
        check("async_mem_err", mem_err, 6'd0);
        check("async_cycle", cycle_count, 32'd0);
        check("async_retire", retire_count, 32'd0);
        clear_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        pmem_resp = 2'b01;
        tick();
        pmem_resp = 2'b00;
        check("post_rst_resp_mem_err", mem_err, 6'b000100);
        check("post_rst_resp_status", status, 2'd3);
        $display("step async_reset: status=%0d mem_err=%b", status, mem_err);

        // Halt match and protocol error on the same edge: fault wins.
        do_reset();
        pc_out = 32'h0000011c;
        for (int e = 1; e <= 20; e++) begin
            load_pc    = (e == 10) || (e == 20);
            pmem_read  = (e == 20) ? 2'b01 : 2'b00;
            pmem_write = (e == 20) ? 2'b01 : 2'b00;
            tick();
        end
        clear_inputs();
        check("fault_vs_halt_status", status, 2'd3);
        check("fault_vs_halt_mem_err", mem_err, 6'b000001);
        check("fault_vs_halt_retire", retire_count, 32'd2);
        $display("step fault_vs_halt: status=%0d mem_err=%b", status, mem_err);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/run_monitor.md
# run_monitor

Synthesizable run-control and bus-protocol monitor for the mp3 pipelined RV32I core. It replaces the ad-hoc halt, timeout and simultaneous-access checks in the top-level bench with one parametrised block. The block sits beside `mp3`, snoops PC-load and physical-memory handshakes on `NUM_CH` ports (I-side, D-side, arbiter), and reports a single sticky run verdict.

## Interface
- `NUM_CH`, 2: number of physical-memory channels checked
- `HALT_ADDR`, 32'h0000011c: PC value that marks the halt loop
- `HALT_COUNT`, 2: number of PC loads to `HALT_ADDR` required to declare halt; legal range 1..255
- `TIMEOUT`, 100000000: cycle budget; legal range 1..2^32-1
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `load_pc`  in  1  PC register loads this cycle
- `pc_out`  in  32  current PC
- `pmem_read`  in  NUM_CH  per-channel read request
- `pmem_write`  in  NUM_CH  per-channel write request
- `pmem_resp`  in  NUM_CH  per-channel response
- `status`  out  2  0 RUN, 1 HALTED, 2 TIMEOUT, 3 FAULT
- `done`  out  1  `status != RUN`
- `mem_err`  out  3*NUM_CH  sticky error flags; bits [3c+2:3c] belong to channel c
- `cycle_count`  out  32  cycles spent in RUN, saturating at 2^32-1
- `retire_count`  out  32  `load_pc` cycles seen in RUN, saturating

## Operation
- Top FSM: RUN -> HALTED | TIMEOUT | FAULT. All three targets are terminal and are left only by `rst`.
- Halt: 8-bit match counter increments on each RUN cycle with `load_pc && pc_out == HALT_ADDR`. The match that brings the count to `HALT_COUNT` moves the FSM to HALTED.
- Timeout: 32-bit down-counter loaded with `TIMEOUT-1` on reset, decrements each RUN cycle. A RUN cycle that samples the counter at 0 moves the FSM to TIMEOUT.
- Per-channel FSM, states IDLE/RD/WR:
  - IDLE, read only: go to RD. IDLE, write only: go to WR.
  - If `pmem_resp` is high in the starting cycle, the transfer completes and the FSM stays IDLE.
  - RD/WR: the request line must stay high and the other low until `pmem_resp`. On resp, return to IDLE. A new request may start the cycle after resp.
- Error bits per channel c, sticky:
  - bit 0: `pmem_read[c] && pmem_write[c]` in any cycle.
  - bit 1: request dropped or switched before resp. The channel FSM returns to IDLE.
  - bit 2: `pmem_resp[c]` while IDLE and no request present.
- Any new error bit moves the FSM to FAULT.
- Same-cycle priority: FAULT > HALTED > TIMEOUT.
- Errors continue to be recorded after `done`. Counters and the top FSM freeze once `done`.

## Timing
- Reset values: `status`=0, `done`=0, `mem_err`=0, `cycle_count`=0, `retire_count`=0; match counter 0; timeout counter `TIMEOUT-1`; channel FSMs IDLE.
- All outputs are registered. A condition sampled at edge N is visible after edge N, i.e. one cycle after the triggering input cycle.
- `done` rises in the same cycle as `status` changes and never falls without `rst`.
- `cycle_count` increments on every edge taken in RUN, including the transition edge.
- Reset mid-transfer abandons channel state. A `pmem_resp` arriving after reset deassertion with no request sets bit 2.

## Configuration
- `RUN_MONITOR_STALL_EN` defined: every RUN cycle with `load_pc` reloads the timeout counter with `TIMEOUT-1`. TIMEOUT then means `TIMEOUT` consecutive cycles with no PC load (stall/deadlock detection).
- Undefined: the counter is never reloaded. TIMEOUT is an absolute cycle budget from reset.

## Test plan
- `HALT_COUNT`=2: pulse `load_pc` with `pc_out`=0x11c at cycles 10 and 20 -> `status`=1 after cycle 20's edge; `retire_count`=2; `cycle_count` frozen.
- `TIMEOUT`=50, no `load_pc` -> `status`=2 after the 50th edge. With `RUN_MONITOR_STALL_EN` and `load_pc` every 40 cycles -> stays 0 indefinitely.
- Channel 1: `pmem_read`=`pmem_write`=1 for one cycle -> `mem_err[3]`=1, `status`=3 next cycle.
- Channel 0: read held 5 cycles, resp on cycle 5, then write with resp in the same cycle -> no error; back-to-back transfers accepted.
- Channel 0: read dropped at cycle 3 before resp, then later a resp arrives while IDLE -> `mem_err[1]` then `mem_err[2]` set; `status`=3.
- Same cycle: halt match and protocol error -> `status`=3. Assert `rst` mid-RUN -> all outputs return to reset values asynchronously.
